// File: rtl/aes_pkg.sv
// Shared AES constants and GF(2^8) helpers for the decrypt core: S-boxes, rcon, FSM state type.
package aes_pkg;

   localparam int AES_NR = 10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_KEXP  = 2'd1,
      ST_ROUND = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [7:0] SBOX [256] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
   };

   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
      8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
      8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
      8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
      8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
      8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
      8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
      8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
      8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
      8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
      8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
      8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
      8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
      8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
      8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
      8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
   };

   localparam logic [7:0] RCON [1:AES_NR] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

endpackage

// File: rtl/aes_inv_128_inv_round.sv
// One AES inverse round, purely combinational: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless i_last marks the final round.
module inv_round
   import aes_pkg::*;
(
   input  logic [127:0] i_s,
   input  logic [127:0] i_rk,
   input  logic         i_last,
   output logic [127:0] o_s
);

   logic [127:0] w_ark;
   logic [127:0] w_mix;

   // Byte k sits at row k%4, column k/4; row r rotates right by r columns.
   always_comb begin
      w_ark = '0;
      for (int k = 0; k < 16; k++) begin
         w_ark[127-8*k -: 8] =
            INV_SBOX[i_s[127-8*((k % 4) + 4*(((k / 4) + 4 - (k % 4)) % 4)) -: 8]]
            ^ i_rk[127-8*k -: 8];
      end
   end

   for (genvar c = 0; c < 4; c++) begin : g_col
      logic [7:0] w_a0, w_a1, w_a2, w_a3;
      assign w_a0 = w_ark[127-32*c      -: 8];
      assign w_a1 = w_ark[127-32*c - 8  -: 8];
      assign w_a2 = w_ark[127-32*c - 16 -: 8];
      assign w_a3 = w_ark[127-32*c - 24 -: 8];
      assign w_mix[127-32*c      -: 8] = gmul(w_a0, 8'h0e) ^ gmul(w_a1, 8'h0b) ^ gmul(w_a2, 8'h0d) ^ gmul(w_a3, 8'h09);
      assign w_mix[127-32*c - 8  -: 8] = gmul(w_a0, 8'h09) ^ gmul(w_a1, 8'h0e) ^ gmul(w_a2, 8'h0b) ^ gmul(w_a3, 8'h0d);
      assign w_mix[127-32*c - 16 -: 8] = gmul(w_a0, 8'h0d) ^ gmul(w_a1, 8'h09) ^ gmul(w_a2, 8'h0e) ^ gmul(w_a3, 8'h0b);
      assign w_mix[127-32*c - 24 -: 8] = gmul(w_a0, 8'h0b) ^ gmul(w_a1, 8'h0d) ^ gmul(w_a2, 8'h09) ^ gmul(w_a3, 8'h0e);
   end

   assign o_s = i_last ? w_ark : w_mix;

endmodule

// File: rtl/aes_inv_128.sv
// Iterative AES-128 decryptor: expands the key schedule on chip, then runs ten inverse rounds.
// Define AES_INV_KEY_CACHE_EN to keep the last schedule and skip expansion when the key repeats.
module aes_inv_128
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] ct,
   input  logic [127:0] key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] pt
);

   state_t       r_state;
   state_t       w_state_nxt;
   logic [3:0]   r_cnt;
   logic [127:0] r_rk [0:AES_NR];
   logic [127:0] r_ct;
   logic [127:0] r_s;
   logic [127:0] r_pt;
   logic [127:0] w_rk_new;
   logic [127:0] w_round;
   logic         w_accept;
   logic         w_kexp_last;
   logic         w_skip;

   function automatic logic [127:0] expand(input logic [127:0] prev, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3, t;
      w3 = prev[31:0];
      t  = {SBOX[w3[23:16]], SBOX[w3[15:8]], SBOX[w3[7:0]], SBOX[w3[31:24]]} ^ {rc, 24'h000000};
      w0 = prev[127:96] ^ t;
      w1 = prev[95:64]  ^ w0;
      w2 = prev[63:32]  ^ w1;
      w3 = w3           ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   assign w_accept    = in_valid && (r_state == ST_IDLE);
   assign w_kexp_last = (r_state == ST_KEXP) && (r_cnt == 4'(AES_NR));
   assign w_rk_new    = expand(r_rk[r_cnt - 4'd1], RCON[r_cnt]);

`ifdef AES_INV_KEY_CACHE_EN
   logic r_cache_vld;
   logic r_hit;

   // A miss overwrites rk[0] immediately, so the cache is invalid until the schedule is rebuilt.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cache_vld <= 1'b0;
         r_hit       <= 1'b0;
      end else if (w_accept) begin
         r_hit <= r_cache_vld && (key == r_rk[0]);
         if (!(r_cache_vld && (key == r_rk[0]))) r_cache_vld <= 1'b0;
      end else if (w_kexp_last && !r_hit) begin
         r_cache_vld <= 1'b1;
      end
   end

   assign w_skip = r_hit;
`else
   assign w_skip = 1'b0;
`endif

   inv_round u_inv_round (
      .i_s    (r_s),
      .i_rk   (r_rk[r_cnt]),
      .i_last (r_cnt == 4'd0),
      .o_s    (w_round)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (in_valid)                w_state_nxt = ST_KEXP;
         ST_KEXP:  if (w_skip || w_kexp_last)   w_state_nxt = ST_ROUND;
         ST_ROUND: if (r_cnt == 4'd0)           w_state_nxt = ST_DONE;
         ST_DONE:  if (out_ready)               w_state_nxt = ST_IDLE;
         default:                               w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (r_state == ST_IDLE);
      out_valid = (r_state == ST_DONE);
      pt        = r_pt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= 4'd0;
         r_s   <= '0;
         r_pt  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: if (in_valid) r_cnt <= 4'd1;
            ST_KEXP: begin
               if (w_skip) begin
                  r_s   <= r_ct ^ r_rk[AES_NR];
                  r_cnt <= 4'd9;
               end else if (w_kexp_last) begin
                  r_s   <= r_ct ^ w_rk_new;
                  r_cnt <= 4'd9;
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            ST_ROUND: begin
               r_s <= w_round;
               if (r_cnt == 4'd0) r_pt  <= w_round;
               else               r_cnt <= r_cnt - 4'd1;
            end
            default: ;
         endcase
      end
   end

   // Ciphertext and key schedule are pure data and need no reset.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_ct     <= ct;
         r_rk[0]  <= key;
      end
      if ((r_state == ST_KEXP) && !w_skip) r_rk[r_cnt] <= w_rk_new;
   end

endmodule
